mop_queue: RTL and testbench
============================

MOP_QUEUE -- requirements
Module: mop_queue

Interface
REQ-001 Parameter DEPTH, default 16, queue capacity in micro-ops; SHALL be a power of 2 and at least IN_W+OUT_W.
REQ-002 Parameter IN_W, default MAX_MOP_CNT (6), micro-op slots per input bundle.
REQ-003 Parameter OUT_W, default 2, micro-op slots presented per cycle to issue.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  bundle from the cracker is present.
REQ-007 in_cnt  input  $clog2(IN_W+1)  number of valid micro-ops in bundle, 0..IN_W.
REQ-008 in_mops  input  IN_W x micro_op_t  cracked micro-ops; slot 0 is oldest.
REQ-009 in_ready  output  1  queue can accept one full bundle this cycle.
REQ-010 out_cnt  output  $clog2(OUT_W+1)  number of valid output slots, 0..OUT_W.
REQ-011 out_mops  output  OUT_W x micro_op_t  oldest queued micro-ops; slot 0 is head.
REQ-012 out_eoi  output  OUT_W  per slot: micro-op is the last of its x86 instruction.
REQ-013 out_take  input  $clog2(OUT_W+1)  number of head micro-ops consumed this cycle.
REQ-014 flush  input  1  discard all queued micro-ops (branch redirect).
REQ-015 occupancy  output  $clog2(DEPTH+1)  current entry count.

Function
REQ-016 in_ready SHALL be 1 iff DEPTH - occupancy >= IN_W, computed from registered occupancy only; it SHALL NOT depend on in_cnt or out_take.
REQ-017 A bundle SHALL be accepted when in_valid && in_ready && !flush; entries in_mops[0..in_cnt-1] are written at tail..tail+in_cnt-1 (mod DEPTH) in slot order.
REQ-018 On acceptance the entry written from slot in_cnt-1 SHALL store eoi=1; all other entries of the bundle SHALL store eoi=0.
REQ-019 An accepted bundle with in_cnt=0 SHALL write nothing and change no state.
REQ-020 in_cnt > IN_W SHALL be clamped to IN_W.
REQ-021 out_cnt SHALL equal min(occupancy, OUT_W); out_mops[i] and out_eoi[i] SHALL be read combinationally from head+i (mod DEPTH) for i < out_cnt; slots i >= out_cnt SHALL output zero.
REQ-022 Latency: a micro-op accepted in cycle t SHALL be visible on out_mops no earlier than cycle t+1 (no input-to-output bypass).
REQ-023 Dequeue count SHALL be min(out_take, out_cnt); head advances by that count mod DEPTH.
REQ-024 Simultaneous accept and dequeue SHALL give occupancy_next = occupancy + in_cnt - dequeue count.
REQ-025 Head and tail pointers SHALL wrap modulo DEPTH; a bundle straddling the wrap point SHALL be stored contiguously in logical order.
REQ-026 flush SHALL, in the same edge, set head=tail=0 and occupancy=0; it SHALL take priority over a same-cycle accept and dequeue, and both SHALL be ignored.
REQ-027 occupancy SHALL never exceed DEPTH and never go negative under any legal or clamped input.

Reset
REQ-028 On reset_n low, head, tail and occupancy SHALL clear to 0 asynchronously; out_cnt=0, out_mops=0, out_eoi=0 and in_ready=1 while in reset.
REQ-029 The storage array SHALL NOT be reset; entries are qualified by occupancy only.
REQ-030 Reset asserted mid-operation SHALL discard all queued micro-ops; the first accept after release SHALL write to index 0.

Structure
REQ-031 micro_op_t and MAX_MOP_CNT SHALL be taken from package MicroOp; the new typedef mop_entry_t {micro_op_t mop; logic eoi;} SHALL be added to that package.
REQ-032 Storage SHALL be an inline DEPTH-entry mop_entry_t register array; no sub-module is required.

Verification
REQ-033 Reset, then one bundle in_cnt=4 (add mem,reg crack) -> next cycle out_cnt=2, out_eoi=00; take 2 twice -> second pair out_eoi[1]=1, occupancy 0.
REQ-034 DEPTH=16: accept bundles of 6, 6 -> occupancy 12, in_ready=0; take 2 -> occupancy 10, in_ready=1 the following cycle.
REQ-035 Wrap: head=tail=14, accept in_cnt=5 -> entries at indices 14,15,0,1,2; drained in order with eoi on the fifth.
REQ-036 Same cycle: in_valid, in_cnt=3, out_take=2, occupancy 5 -> occupancy 6; out_take=2 with occupancy 1 -> dequeue 1, occupancy 0.
REQ-037 flush asserted with in_valid and out_take=2 at occupancy 7 -> occupancy 0, out_cnt 0 next cycle, bundle not stored.
REQ-038 reset_n pulsed low between clock edges at occupancy 9 -> outputs clear immediately; next bundle of 1 appears at out_mops[0] with eoi=1.

Source files
------------

// File: rtl/mop_queue_pkg.sv
// Shared micro-op types: the cracker's micro-op record and the queue entry that
// pairs each micro-op with its end-of-instruction marker.
package MicroOp;

    localparam int MAX_MOP_CNT = 6;

    typedef struct packed {
        logic [7:0] opc;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [8:0] imm;
    } micro_op_t;

    typedef struct packed {
        micro_op_t mop;
        logic      eoi;
    } mop_entry_t;

endpackage

// File: rtl/mop_queue.sv
// Micro-op queue between the x86 cracker and issue: accepts whole bundles,
// presents up to OUT_W oldest micro-ops per cycle, and flushes on redirect.
module mop_queue
    import MicroOp::*;
#(
    parameter int DEPTH = 16,
    parameter int IN_W  = MAX_MOP_CNT,
    parameter int OUT_W = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    input  logic [$clog2(IN_W+1)-1:0]     in_cnt,
    input  micro_op_t [IN_W-1:0]          in_mops,
    output logic                          in_ready,
    output logic [$clog2(OUT_W+1)-1:0]    out_cnt,
    output micro_op_t [OUT_W-1:0]         out_mops,
    output logic [OUT_W-1:0]              out_eoi,
    input  logic [$clog2(OUT_W+1)-1:0]    out_take,
    input  logic                          flush,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int IN_CW  = $clog2(IN_W+1);
    localparam int OUT_CW = $clog2(OUT_W+1);

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [IN_CW-1:0]  acc_cnt;
    logic              accept;
    logic [OUT_CW-1:0] deq_cnt;
    logic [CNT_W-1:0]  add_cnt;

    mop_entry_t mem [DEPTH];

    // Readiness is sized for a full bundle so it never waits on in_cnt or out_take.
    assign in_ready = (occupancy <= CNT_W'(DEPTH - IN_W));

    always_comb begin
        acc_cnt = (in_cnt > IN_CW'(IN_W)) ? IN_CW'(IN_W) : in_cnt;
        accept  = in_valid && in_ready && !flush && (acc_cnt != '0);
        add_cnt = accept ? CNT_W'(acc_cnt) : '0;
        out_cnt = (occupancy >= CNT_W'(OUT_W)) ? OUT_CW'(OUT_W) : OUT_CW'(occupancy);
        deq_cnt = (out_take > out_cnt) ? out_cnt : out_take;
    end

    // NOTE: every output slot gets a zero default before the conditional read,
    // so no latch is inferred for slots beyond out_cnt.
    always_comb begin
        for (int i = 0; i < OUT_W; i++) begin
            out_mops[i] = '0;
            out_eoi[i]  = 1'b0;
            if (i < int'(out_cnt)) begin
                out_mops[i] = mem[head + PTR_W'(i)].mop;
                out_eoi[i]  = mem[head + PTR_W'(i)].eoi;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every pointer
    // update sees the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            tail      <= tail + PTR_W'(add_cnt);
            head      <= head + PTR_W'(deq_cnt);
            occupancy <= occupancy + add_cnt - CNT_W'(deq_cnt);
        end
    end

    // NOTE: the storage array has no reset; entries are only meaningful while
    // covered by occupancy, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < IN_W; i++) begin
                if (i < int'(acc_cnt)) begin
                    mem[tail + PTR_W'(i)] <= '{mop: in_mops[i], eoi: (i == int'(acc_cnt) - 1)};
                end
            end
        end
    end

endmodule

// File: tb/tb_mop_queue.sv
// Directed bench for mop_queue: reset, latency, clamp, full/ready, wrap,
// simultaneous accept/dequeue, flush priority and mid-cycle reset.
module tb_mop_queue;
    import MicroOp::*;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 in_valid;
    logic [2:0]           in_cnt;
    micro_op_t [5:0]      in_mops;
    logic                 in_ready;
    logic [1:0]           out_cnt;
    micro_op_t [1:0]      out_mops;
    logic [1:0]           out_eoi;
    logic [1:0]           out_take;
    logic                 flush;
    logic [4:0]           occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    mop_queue dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_cnt    (in_cnt),
        .in_mops   (in_mops),
        .in_ready  (in_ready),
        .out_cnt   (out_cnt),
        .out_mops  (out_mops),
        .out_eoi   (out_eoi),
        .out_take  (out_take),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    function automatic micro_op_t mk(input int n);
        micro_op_t m;
        m.opc = 8'(n);
        m.rd  = 5'(n);
        m.rs1 = 5'(n + 3);
        m.rs2 = 5'(n + 7);
        m.imm = 9'(n * 5);
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_cnt   = '0;
        out_take = '0;
        flush    = 1'b0;
    endtask

    task automatic load(input int base);
        for (int i = 0; i < 6; i++) in_mops[i] = mk(base + i);
    endtask

    task automatic push(input int cnt, input int base);
        in_valid = 1'b1;
        in_cnt   = 3'(cnt);
        load(base);
        step();
        idle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        in_mops = '0;
        #3;
        n_cmp++; if (out_cnt !== 2'd0) begin n_bad++; $display("FAIL rst_out_cnt: got %0d want 0", out_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (occupancy !== 5'd0) begin n_bad++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
        n_cmp++; if (out_mops !== '0 || out_eoi !== 2'b00) begin n_bad++; $display("FAIL rst_out_zero: got %h/%b want 0/00", out_mops, out_eoi); end
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        in_valid = 1'b1;
        in_cnt   = 3'd4;
        load(10);
        #1;
        n_cmp++; if (out_cnt !== 2'd0) begin n_bad++; $display("FAIL no_bypass: got %0d want 0", out_cnt); end
        step();
        idle();
        n_cmp++; if (out_cnt !== 2'd2) begin n_bad++; $display("FAIL basic_out_cnt: got %0d want 2", out_cnt); end
        n_cmp++; if (occupancy !== 5'd4) begin n_bad++; $display("FAIL basic_occ: got %0d want 4", occupancy); end
        n_cmp++; if (out_eoi !== 2'b00) begin n_bad++; $display("FAIL basic_eoi0: got %b want 00", out_eoi); end
        n_cmp++; if (out_mops[0] !== mk(10) || out_mops[1] !== mk(11)) begin n_bad++; $display("FAIL basic_pair0: got %h %h want %h %h", out_mops[0], out_mops[1], mk(10), mk(11)); end
        out_take = 2'd2;
        step();
        n_cmp++; if (out_mops[0] !== mk(12) || out_mops[1] !== mk(13)) begin n_bad++; $display("FAIL basic_pair1: got %h %h want %h %h", out_mops[0], out_mops[1], mk(12), mk(13)); end
        n_cmp++; if (out_eoi !== 2'b10) begin n_bad++; $display("FAIL basic_eoi1: got %b want 10", out_eoi); end
        step();
        idle();
        n_cmp++; if (occupancy !== 5'd0 || out_cnt !== 2'd0) begin n_bad++; $display("FAIL basic_empty: got occ %0d cnt %0d want 0 0", occupancy, out_cnt); end
        n_cmp++; if (out_mops !== '0) begin n_bad++; $display("FAIL basic_zero_slots: got %h want 0", out_mops); end
    endtask

    task automatic test_zero_and_clamp();
        push(0, 0);
        n_cmp++; if (occupancy !== 5'd0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL zero_cnt: got occ %0d rdy %b want 0 1", occupancy, in_ready); end
        push(7, 20);
        n_cmp++; if (occupancy !== 5'd6) begin n_bad++; $display("FAIL clamp_occ: got %0d want 6", occupancy); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (out_mops[0] !== mk(20 + 2*k) || out_mops[1] !== mk(21 + 2*k)) begin n_bad++; $display("FAIL clamp_pair%0d: got %h %h want %h %h", k, out_mops[0], out_mops[1], mk(20 + 2*k), mk(21 + 2*k)); end
            n_cmp++; if (out_eoi !== ((k == 2) ? 2'b10 : 2'b00)) begin n_bad++; $display("FAIL clamp_eoi%0d: got %b", k, out_eoi); end
            out_take = 2'd2;
            step();
        end
        idle();
        n_cmp++; if (occupancy !== 5'd0) begin n_bad++; $display("FAIL clamp_drain: got %0d want 0", occupancy); end
    endtask

    task automatic test_full();
        int         exp_tag [10] = '{32, 33, 34, 35, 40, 41, 42, 43, 44, 45};
        logic [1:0] exp_eoi [5]  = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b10};
        push(6, 30);
        push(6, 40);
        n_cmp++; if (occupancy !== 5'd12) begin n_bad++; $display("FAIL full_occ: got %0d want 12", occupancy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_not_ready: got %b want 0", in_ready); end
        in_valid = 1'b1;
        in_cnt   = 3'd6;
        load(50);
        out_take = 2'd2;
        step();
        idle();
        n_cmp++; if (occupancy !== 5'd10) begin n_bad++; $display("FAIL full_take_occ: got %0d want 10", occupancy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_again: got %b want 1", in_ready); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (out_mops[0] !== mk(exp_tag[2*k]) || out_mops[1] !== mk(exp_tag[2*k+1]) || out_eoi !== exp_eoi[k]) begin
                n_bad++; $display("FAIL full_drain%0d: got %h %h %b want %h %h %b", k, out_mops[0], out_mops[1], out_eoi, mk(exp_tag[2*k]), mk(exp_tag[2*k+1]), exp_eoi[k]);
            end
            out_take = 2'd2;
            step();
        end
        idle();
        n_cmp++; if (occupancy !== 5'd0) begin n_bad++; $display("FAIL full_drain_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_wrap();
        push(6, 0);
        push(2, 0);
        out_take = 2'd2;
        repeat (4) step();
        idle();
        n_cmp++; if (occupancy !== 5'd0 || out_cnt !== 2'd0) begin n_bad++; $display("FAIL wrap_setup: got occ %0d cnt %0d want 0 0", occupancy, out_cnt); end
        push(5, 60);
        n_cmp++; if (occupancy !== 5'd5) begin n_bad++; $display("FAIL wrap_occ: got %0d want 5", occupancy); end
        n_cmp++; if (out_mops[0] !== mk(60) || out_mops[1] !== mk(61) || out_eoi !== 2'b00) begin n_bad++; $display("FAIL wrap_pair0: got %h %h %b", out_mops[0], out_mops[1], out_eoi); end
        out_take = 2'd2;
        step();
        n_cmp++; if (out_mops[0] !== mk(62) || out_mops[1] !== mk(63) || out_eoi !== 2'b00) begin n_bad++; $display("FAIL wrap_pair1: got %h %h %b", out_mops[0], out_mops[1], out_eoi); end
        step();
        idle();
        n_cmp++; if (out_cnt !== 2'd1 || out_mops[0] !== mk(64) || out_mops[1] !== '0 || out_eoi !== 2'b01) begin
            n_bad++; $display("FAIL wrap_last: got cnt %0d %h %h %b want 1 %h 0 01", out_cnt, out_mops[0], out_mops[1], out_eoi, mk(64));
        end
        out_take = 2'd2;
        step();
        idle();
    endtask

    task automatic test_back_to_back();
        push(5, 70);
        n_cmp++; if (occupancy !== 5'd5) begin n_bad++; $display("FAIL b2b_setup: got %0d want 5", occupancy); end
        in_valid = 1'b1;
        in_cnt   = 3'd3;
        load(80);
        out_take = 2'd2;
        step();
        idle();
        n_cmp++; if (occupancy !== 5'd6) begin n_bad++; $display("FAIL b2b_occ: got %0d want 6", occupancy); end
        n_cmp++; if (out_mops[0] !== mk(72)) begin n_bad++; $display("FAIL b2b_head: got %h want %h", out_mops[0], mk(72)); end
        out_take = 2'd2;
        step();
        n_cmp++; if (out_mops[0] !== mk(74) || out_mops[1] !== mk(80) || out_eoi !== 2'b01 || occupancy !== 5'd4) begin
            n_bad++; $display("FAIL b2b_boundary: got %h %h %b occ %0d", out_mops[0], out_mops[1], out_eoi, occupancy);
        end
        step();
        out_take = 2'd1;
        step();
        n_cmp++; if (occupancy !== 5'd1 || out_cnt !== 2'd1 || out_mops[0] !== mk(82) || out_eoi !== 2'b01) begin
            n_bad++; $display("FAIL b2b_one_left: got occ %0d cnt %0d %h %b", occupancy, out_cnt, out_mops[0], out_eoi);
        end
        out_take = 2'd2;
        step();
        idle();
        n_cmp++; if (occupancy !== 5'd0 || out_cnt !== 2'd0) begin n_bad++; $display("FAIL b2b_overtake: got occ %0d cnt %0d want 0 0", occupancy, out_cnt); end
    endtask

    task automatic test_flush();
        push(6, 90);
        push(1, 100);
        n_cmp++; if (occupancy !== 5'd7) begin n_bad++; $display("FAIL flush_setup: got %0d want 7", occupancy); end
        in_valid = 1'b1;
        in_cnt   = 3'd3;
        load(110);
        out_take = 2'd2;
        flush    = 1'b1;
        step();
        idle();
        n_cmp++; if (occupancy !== 5'd0 || out_cnt !== 2'd0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL flush_clear: got occ %0d cnt %0d rdy %b want 0 0 1", occupancy, out_cnt, in_ready);
        end
        push(1, 120);
        n_cmp++; if (occupancy !== 5'd1 || out_mops[0] !== mk(120) || out_mops[1] !== '0 || out_eoi !== 2'b01) begin
            n_bad++; $display("FAIL flush_after: got occ %0d %h %h %b want 1 %h 0 01", occupancy, out_mops[0], out_mops[1], out_eoi, mk(120));
        end
        out_take = 2'd1;
        step();
        idle();
    endtask

    task automatic test_reset_mid();
        push(6, 130);
        push(3, 140);
        n_cmp++; if (occupancy !== 5'd9) begin n_bad++; $display("FAIL rmid_setup: got %0d want 9", occupancy); end
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (out_cnt !== 2'd0 || occupancy !== 5'd0 || out_mops !== '0 || out_eoi !== 2'b00 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL rmid_async: got cnt %0d occ %0d %h %b rdy %b", out_cnt, occupancy, out_mops, out_eoi, in_ready);
        end
        #1;
        reset_n = 1'b1;
        step();
        push(1, 150);
        n_cmp++; if (out_cnt !== 2'd1 || out_mops[0] !== mk(150) || out_eoi !== 2'b01 || occupancy !== 5'd1) begin
            n_bad++; $display("FAIL rmid_after: got cnt %0d %h %b occ %0d want 1 %h 01 1", out_cnt, out_mops[0], out_eoi, occupancy, mk(150));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_and_clamp();
        test_full();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
